// File: rtl/bpc_cup_col_dec.sv
// Cleanup-pass column sequencer (decoder side) for one 4-sample stripe column.
// Define BPC_VCAUSAL_EN to add the vcausal input (vertically causal context formation).
module bpc_cup_col_dec #(
  parameter logic [4:0] RL_CX  = 5'd0,
  parameter logic [4:0] UNI_CX = 5'd18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       col_start,
  input  logic [1:0] flag_band,
  input  logic       rlc_ok,
  input  logic [3:0] skip,
`ifdef BPC_VCAUSAL_EN
  input  logic       vcausal,
`endif
  output logic [1:0] cur_idx,
  input  logic       h0,
  input  logic       h1,
  input  logic       v0,
  input  logic       v1,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       sign_h0,
  input  logic       sign_h1,
  input  logic       sign_v0,
  input  logic       sign_v1,
  output logic       dec_req,
  output logic [4:0] dec_cx,
  input  logic       dec_ack,
  input  logic       dec_d,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic       out_sig,
  output logic       out_sign,
  output logic       col_done,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, RL, U0, U1, ZC, SC, NXT, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] band_q, band_d;
  logic [3:1] skip_q, skip_d;
  logic       u0_q, u0_d;
  logic [1:0] cur_idx_d, out_idx_d;
  logic       dec_req_d, out_valid_d, out_sig_d, out_sign_d, col_done_d;
  logic       req_state, ack;
  logic       nxt_found;
  logic [1:0] nxt_idx;

  logic       causal_cut;
  logic       v1_e, d2_e, d3_e, sign_v1_e;
  logic [1:0] h_cnt, v_cnt, zc_a, zc_b;
  logic [2:0] d_cnt, hv_cnt;
  logic [4:0] zc_cx, sc_cx;
  logic       sc_xor;
  logic       h_pos, h_neg, v_pos, v_neg;

`ifdef BPC_VCAUSAL_EN
  logic vcausal_q, vcausal_d;
  assign causal_cut = vcausal_q && (cur_idx == 2'd3);
`else
  assign causal_cut = 1'b0;
`endif

  // The last row of the stripe may not look at the stripe below in causal mode.
  assign v1_e      = v1 & ~causal_cut;
  assign d2_e      = d2 & ~causal_cut;
  assign d3_e      = d3 & ~causal_cut;
  assign sign_v1_e = sign_v1 & ~causal_cut;

  assign h_cnt  = {1'b0, h0} + {1'b0, h1};
  assign v_cnt  = {1'b0, v0} + {1'b0, v1_e};
  assign d_cnt  = {2'b0, d0} + {2'b0, d1} + {2'b0, d2_e} + {2'b0, d3_e};
  assign hv_cnt = {1'b0, h_cnt} + {1'b0, v_cnt};

  always_comb begin
    zc_cx = 5'd1;
    zc_a  = (band_q == 2'd1) ? v_cnt : h_cnt;
    zc_b  = (band_q == 2'd1) ? h_cnt : v_cnt;
    if (band_q == 2'd3) begin
      if (d_cnt > 3'd2)       zc_cx = 5'd9;
      else if (d_cnt == 3'd2) zc_cx = (hv_cnt != 3'd0) ? 5'd8 : 5'd7;
      else if (d_cnt == 3'd1) zc_cx = (hv_cnt > 3'd1) ? 5'd6 : (hv_cnt == 3'd1) ? 5'd5 : 5'd4;
      else                    zc_cx = (hv_cnt > 3'd1) ? 5'd3 : (hv_cnt == 3'd1) ? 5'd2 : 5'd1;
    end else begin
      if (zc_a == 2'd2)       zc_cx = 5'd9;
      else if (zc_a == 2'd1)  zc_cx = (zc_b != 2'd0) ? 5'd8 : (d_cnt != 3'd0) ? 5'd7 : 5'd6;
      else if (zc_b == 2'd2)  zc_cx = 5'd5;
      else if (zc_b == 2'd1)  zc_cx = 5'd4;
      else if (d_cnt > 3'd1)  zc_cx = 5'd3;
      else if (d_cnt == 3'd1) zc_cx = 5'd2;
      else                    zc_cx = 5'd1;
    end
  end

  assign h_pos = (h0 & ~sign_h0) | (h1 & ~sign_h1);
  assign h_neg = (h0 & sign_h0) | (h1 & sign_h1);
  assign v_pos = (v0 & ~sign_v0) | (v1_e & ~sign_v1_e);
  assign v_neg = (v0 & sign_v0) | (v1_e & sign_v1_e);

  // Key is {h +1, h -1, v +1, v -1}; mixed-sign sides collapse to 0.
  always_comb begin
    sc_cx  = 5'd13;
    sc_xor = 1'b0;
    case ({h_pos & ~h_neg, h_neg & ~h_pos, v_pos & ~v_neg, v_neg & ~v_pos})
      4'b1010: begin sc_cx = 5'd17; sc_xor = 1'b0; end
      4'b1000: begin sc_cx = 5'd16; sc_xor = 1'b0; end
      4'b1001: begin sc_cx = 5'd15; sc_xor = 1'b0; end
      4'b0010: begin sc_cx = 5'd14; sc_xor = 1'b0; end
      4'b0001: begin sc_cx = 5'd14; sc_xor = 1'b1; end
      4'b0110: begin sc_cx = 5'd15; sc_xor = 1'b1; end
      4'b0100: begin sc_cx = 5'd16; sc_xor = 1'b1; end
      4'b0101: begin sc_cx = 5'd17; sc_xor = 1'b1; end
      default: begin sc_cx = 5'd13; sc_xor = 1'b0; end
    endcase
  end

  assign dec_cx = !dec_req ? 5'd0 :
                  (state_q == RL) ? RL_CX :
                  (state_q == U0 || state_q == U1) ? UNI_CX :
                  (state_q == ZC) ? zc_cx : sc_cx;

  assign req_state = (state_q == RL) || (state_q == U0) || (state_q == U1) ||
                     (state_q == ZC) || (state_q == SC);
  assign ack       = dec_req & dec_ack;

  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = cur_idx;
    if (cur_idx == 2'd0 && !skip_q[1]) begin
      nxt_found = 1'b1;
      nxt_idx   = 2'd1;
    end else if (cur_idx <= 2'd1 && !skip_q[2]) begin
      nxt_found = 1'b1;
      nxt_idx   = 2'd2;
    end else if (cur_idx <= 2'd2 && !skip_q[3]) begin
      nxt_found = 1'b1;
      nxt_idx   = 2'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    band_d      = band_q;
    skip_d      = skip_q;
    u0_d        = u0_q;
    cur_idx_d   = cur_idx;
    dec_req_d   = req_state & ~ack;
    out_valid_d = 1'b0;
    out_idx_d   = 2'd0;
    out_sig_d   = 1'b0;
    out_sign_d  = 1'b0;
`ifdef BPC_VCAUSAL_EN
    vcausal_d   = vcausal_q;
`endif
    case (state_q)
      IDLE: begin
        if (col_start) begin
          band_d    = flag_band;
          skip_d    = skip[3:1];
          cur_idx_d = 2'd0;
`ifdef BPC_VCAUSAL_EN
          vcausal_d = vcausal;
`endif
          if (rlc_ok)       state_d = RL;
          else if (skip[0]) state_d = NXT;
          else              state_d = ZC;
        end
      end
      RL: if (ack) state_d = dec_d ? U0 : DONE;
      U0: begin
        if (ack) begin
          u0_d    = dec_d;
          state_d = U1;
        end
      end
      // The run-length position lands directly on the first significant sample.
      U1: begin
        if (ack) begin
          cur_idx_d = {u0_q, dec_d};
          state_d   = SC;
        end
      end
      ZC: begin
        if (ack) begin
          if (dec_d) begin
            state_d = SC;
          end else begin
            out_valid_d = 1'b1;
            out_idx_d   = cur_idx;
            state_d     = NXT;
          end
        end
      end
      SC: begin
        if (ack) begin
          out_valid_d = 1'b1;
          out_idx_d   = cur_idx;
          out_sig_d   = 1'b1;
          out_sign_d  = dec_d ^ sc_xor;
          state_d     = NXT;
        end
      end
      NXT: begin
        if (nxt_found) begin
          cur_idx_d = nxt_idx;
          state_d   = ZC;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    col_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      band_q    <= 2'd0;
      skip_q    <= 3'd0;
      u0_q      <= 1'b0;
      cur_idx   <= 2'd0;
      dec_req   <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= 2'd0;
      out_sig   <= 1'b0;
      out_sign  <= 1'b0;
      col_done  <= 1'b0;
      busy      <= 1'b0;
`ifdef BPC_VCAUSAL_EN
      vcausal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      band_q    <= band_d;
      skip_q    <= skip_d;
      u0_q      <= u0_d;
      cur_idx   <= cur_idx_d;
      dec_req   <= dec_req_d;
      out_valid <= out_valid_d;
      out_idx   <= out_idx_d;
      out_sig   <= out_sig_d;
      out_sign  <= out_sign_d;
      col_done  <= col_done_d;
      busy      <= (state_d != IDLE);
`ifdef BPC_VCAUSAL_EN
      vcausal_q <= vcausal_d;
`endif
    end
  end

endmodule

// File: tb/tb_bpc_cup_col_dec.sv
// Directed bench for bpc_cup_col_dec: scripted MQ decisions against hand-computed contexts and results.
module tb_bpc_cup_col_dec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       col_start = 1'b0;
  logic [1:0] flag_band = 2'd0;
  logic       rlc_ok = 1'b0;
  logic [3:0] skip = 4'd0;
  logic [1:0] cur_idx;
  logic       h0 = 0, h1 = 0, v0 = 0, v1 = 0, d0 = 0, d1 = 0, d2 = 0, d3 = 0;
  logic       sign_h0 = 0, sign_h1 = 0, sign_v0 = 0, sign_v1 = 0;
  logic       dec_req;
  logic [4:0] dec_cx;
  logic       dec_ack = 1'b0;
  logic       dec_d = 1'b0;
  logic       out_valid;
  logic [1:0] out_idx;
  logic       out_sig;
  logic       out_sign;
  logic       col_done;
  logic       busy;
`ifdef BPC_VCAUSAL_EN
  logic       vcausal = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int ov_cnt = 0;
  int done_cnt = 0;
  int ack_cnt = 0;

  bpc_cup_col_dec dut (
    .clk(clk), .rst_n(rst_n), .col_start(col_start), .flag_band(flag_band),
    .rlc_ok(rlc_ok), .skip(skip),
`ifdef BPC_VCAUSAL_EN
    .vcausal(vcausal),
`endif
    .cur_idx(cur_idx),
    .h0(h0), .h1(h1), .v0(v0), .v1(v1), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .sign_h0(sign_h0), .sign_h1(sign_h1), .sign_v0(sign_v0), .sign_v1(sign_v1),
    .dec_req(dec_req), .dec_cx(dec_cx), .dec_ack(dec_ack), .dec_d(dec_d),
    .out_valid(out_valid), .out_idx(out_idx), .out_sig(out_sig), .out_sign(out_sign),
    .col_done(col_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dec_req && dec_ack) ack_cnt++;

  always @(negedge clk) begin
    if (out_valid) ov_cnt++;
    if (col_done) done_cnt++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_nb(input logic [7:0] sig, input logic [3:0] sgn);
    {h0, h1, v0, v1, d0, d1, d2, d3} = sig;
    {sign_h0, sign_h1, sign_v0, sign_v1} = sgn;
  endtask

  task automatic start_col(input logic [1:0] band, input logic rlc, input logic [3:0] skp);
    flag_band = band;
    rlc_ok    = rlc;
    skip      = skp;
    col_start = 1'b1;
    @(negedge clk);
    col_start = 1'b0;
  endtask

  task automatic wait_req(output bit got, output logic [4:0] cx, output logic [1:0] idx);
    got = 0;
    cx  = 5'd0;
    idx = 2'd0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dec_req) begin
        got = 1;
        cx  = dec_cx;
        idx = cur_idx;
      end
    end
  endtask

  task automatic give_dec(input logic d);
    dec_ack = 1'b1;
    dec_d   = d;
    @(negedge clk);
    dec_ack = 1'b0;
    dec_d   = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (col_done) got = 1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({dec_req, dec_cx, out_valid, out_idx, out_sig, out_sign, col_done, busy} !== 13'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got=%b want=0", {dec_req, dec_cx, out_valid, out_idx, out_sig, out_sign, col_done, busy});
    end
    total++;
    if (cur_idx !== 2'd0) begin bad++; $display("[TB] FAIL reset_cur_idx: got=%0d want=0", cur_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rl_zero;
    bit got; logic [4:0] cx; logic [1:0] idx; int ov0, ak0;
    set_nb(8'd0, 4'd0);
    ov0 = ov_cnt; ak0 = ack_cnt;
    start_col(2'd0, 1'b1, 4'b0000);
    wait_req(got, cx, idx);
    total++;
    if (!got || cx !== 5'd0) begin bad++; $display("[TB] FAIL rl0_cx: got=%0d cx=%0d want=0", got, cx); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rl0_busy: got=%b want=1", busy); end
    give_dec(1'b0);
    total++;
    if (dec_req !== 1'b0) begin bad++; $display("[TB] FAIL rl0_req_drop: got=%b want=0", dec_req); end
    wait_done(got);
    total++;
    if (!got) begin bad++; $display("[TB] FAIL rl0_done: col_done not seen"); end
    @(negedge clk);
    total++;
    if (ov_cnt - ov0 !== 0 || ack_cnt - ak0 !== 1) begin
      bad++; $display("[TB] FAIL rl0_counts: out_valid=%0d acks=%0d want 0/1", ov_cnt - ov0, ack_cnt - ak0);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rl0_idle_busy: got=%b want=0", busy); end
  endtask

  task automatic test_rl_uniform;
    bit got; logic [4:0] cx; logic [1:0] idx; int ov0, ak0;
    logic [4:0] exp_cx [3];
    logic       dv [3];
    exp_cx = '{5'd0, 5'd18, 5'd18};
    dv     = '{1'b1, 1'b1, 1'b0};
    set_nb(8'd0, 4'd0);
    ov0 = ov_cnt; ak0 = ack_cnt;
    start_col(2'd0, 1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      wait_req(got, cx, idx);
      total++;
      if (!got || cx !== exp_cx[k]) begin bad++; $display("[TB] FAIL rlu_cx%0d: got=%0d cx=%0d want=%0d", k, got, cx, exp_cx[k]); end
      give_dec(dv[k]);
    end
    total++;
    if (cur_idx !== 2'd2 || ov_cnt != ov0 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL rlu_pos: cur_idx=%0d outputs=%0d want idx 2 and no output", cur_idx, ov_cnt - ov0);
    end
    wait_req(got, cx, idx);
    total++;
    if (!got || cx !== 5'd13 || idx !== 2'd2) begin bad++; $display("[TB] FAIL rlu_sc: cx=%0d idx=%0d want 13/2", cx, idx); end
    give_dec(1'b1);
    total++;
    if ({out_valid, out_idx, out_sig, out_sign} !== {1'b1, 2'd2, 1'b1, 1'b1}) begin
      bad++; $display("[TB] FAIL rlu_out2: got=%b want=11011", {out_valid, out_idx, out_sig, out_sign});
    end
    wait_req(got, cx, idx);
    total++;
    if (!got || cx !== 5'd1 || idx !== 2'd3) begin bad++; $display("[TB] FAIL rlu_zc3: cx=%0d idx=%0d want 1/3", cx, idx); end
    give_dec(1'b0);
    total++;
    if ({out_valid, out_idx, out_sig, out_sign} !== {1'b1, 2'd3, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL rlu_out3: got=%b want=11100", {out_valid, out_idx, out_sig, out_sign});
    end
    wait_done(got);
    @(negedge clk);
    total++;
    if (!got || ov_cnt - ov0 !== 2 || ack_cnt - ak0 !== 5) begin
      bad++; $display("[TB] FAIL rlu_counts: done=%0d out_valid=%0d acks=%0d want 1/2/5", got, ov_cnt - ov0, ack_cnt - ak0);
    end
  endtask

  task automatic test_lh_zc_sc;
    bit got; logic [4:0] cx; logic [1:0] idx;
    set_nb(8'b1110_0000, 4'b0110);
    start_col(2'd2, 1'b0, 4'b0000);
    wait_req(got, cx, idx);
    total++;
    if (!got || cx !== 5'd9) begin bad++; $display("[TB] FAIL lh_zc: cx=%0d want=9", cx); end
    give_dec(1'b1);
    wait_req(got, cx, idx);
    total++;
    if (!got || cx !== 5'd14) begin bad++; $display("[TB] FAIL lh_sc: cx=%0d want=14", cx); end
    give_dec(1'b0);
    total++;
    if ({out_valid, out_idx, out_sig, out_sign} !== {1'b1, 2'd0, 1'b1, 1'b1}) begin
      bad++; $display("[TB] FAIL lh_out: got=%b want=10011", {out_valid, out_idx, out_sig, out_sign});
    end
    for (int k = 1; k < 4; k++) begin
      wait_req(got, cx, idx);
      total++;
      if (!got || cx !== 5'd9 || idx !== 2'(k)) begin bad++; $display("[TB] FAIL lh_zc%0d: cx=%0d idx=%0d want 9/%0d", k, cx, idx, k); end
      give_dec(1'b0);
    end
    wait_done(got);
    total++;
    if (!got) begin bad++; $display("[TB] FAIL lh_done: col_done not seen"); end
    @(negedge clk);
  endtask

  task automatic test_zc_bands;
    bit got; logic [4:0] cx; logic [1:0] idx;
    logic [14:0] tab [14];
    tab = '{ {2'd0, 8'b1000_1000, 5'd7}, {2'd1, 8'b1100_0000, 5'd5}, {2'd0, 8'b1100_0000, 5'd9},
             {2'd0, 8'b0010_0000, 5'd4}, {2'd0, 8'b0000_1100, 5'd3}, {2'd0, 8'b0000_0000, 5'd1},
             {2'd3, 8'b1000_1100, 5'd8}, {2'd3, 8'b0000_1110, 5'd9}, {2'd3, 8'b1010_1000, 5'd6},
             {2'd3, 8'b1000_0000, 5'd2}, {2'd2, 8'b1001_0000, 5'd8}, {2'd1, 8'b0010_0000, 5'd6},
             {2'd0, 8'b0000_0001, 5'd2}, {2'd3, 8'b0100_0001, 5'd5} };
    for (int k = 0; k < 14; k++) begin
      set_nb(tab[k][12:5], 4'd0);
      start_col(tab[k][14:13], 1'b0, 4'b1110);
      wait_req(got, cx, idx);
      total++;
      if (!got || cx !== tab[k][4:0]) begin bad++; $display("[TB] FAIL zc_tab%0d: cx=%0d want=%0d", k, cx, tab[k][4:0]); end
      give_dec(1'b0);
      total++;
      if ({out_valid, out_idx, out_sig, out_sign} !== 5'b10000) begin
        bad++; $display("[TB] FAIL zc_out%0d: got=%b want=10000", k, {out_valid, out_idx, out_sig, out_sign});
      end
      wait_done(got);
      total++;
      if (!got) begin bad++; $display("[TB] FAIL zc_done%0d: col_done not seen", k); end
      @(negedge clk);
    end
  endtask

  task automatic test_sc_signs;
    bit got; logic [4:0] cx; logic [1:0] idx; logic d;
    logic [13:0] tab [9];
    tab = '{ {4'b1010, 4'b0000, 5'd17, 1'b0}, {4'b1010, 4'b1010, 5'd17, 1'b1},
             {4'b1101, 4'b1001, 5'd14, 1'b1}, {4'b1000, 4'b1000, 5'd16, 1'b1},
             {4'b0101, 4'b0001, 5'd15, 1'b0}, {4'b1010, 4'b1000, 5'd15, 1'b1},
             {4'b0010, 4'b0000, 5'd14, 1'b0}, {4'b0011, 4'b0001, 5'd13, 1'b0},
             {4'b1000, 4'b0100, 5'd16, 1'b0} };
    for (int k = 0; k < 9; k++) begin
      d = 1'(k % 2);
      set_nb({tab[k][13:10], 4'b0000}, tab[k][9:6]);
      start_col(2'd0, 1'b0, 4'b1110);
      wait_req(got, cx, idx);
      give_dec(1'b1);
      wait_req(got, cx, idx);
      total++;
      if (!got || cx !== tab[k][5:1]) begin bad++; $display("[TB] FAIL sc_cx%0d: cx=%0d want=%0d", k, cx, tab[k][5:1]); end
      give_dec(d);
      total++;
      if ({out_valid, out_idx, out_sig, out_sign} !== {1'b1, 2'd0, 1'b1, d ^ tab[k][0]}) begin
        bad++; $display("[TB] FAIL sc_out%0d: got=%b want=%b", k, {out_valid, out_idx, out_sig, out_sign}, {1'b1, 2'd0, 1'b1, d ^ tab[k][0]});
      end
      wait_done(got);
      @(negedge clk);
    end
  endtask

  task automatic test_skip;
    bit got; logic [4:0] cx; logic [1:0] idx; int ov0, ak0;
    set_nb(8'd0, 4'd0);
    ov0 = ov_cnt; ak0 = ack_cnt;
    start_col(2'd0, 1'b0, 4'b1010);
    wait_req(got, cx, idx);
    total++;
    if (!got || idx !== 2'd0 || cx !== 5'd1) begin bad++; $display("[TB] FAIL skip_req0: idx=%0d cx=%0d want 0/1", idx, cx); end
    give_dec(1'b0);
    wait_req(got, cx, idx);
    total++;
    if (!got || idx !== 2'd2 || cx !== 5'd1) begin bad++; $display("[TB] FAIL skip_req2: idx=%0d cx=%0d want 2/1", idx, cx); end
    give_dec(1'b0);
    wait_done(got);
    @(negedge clk);
    total++;
    if (!got || ov_cnt - ov0 !== 2 || ack_cnt - ak0 !== 2) begin
      bad++; $display("[TB] FAIL skip_counts: done=%0d out_valid=%0d acks=%0d want 1/2/2", got, ov_cnt - ov0, ack_cnt - ak0);
    end
  endtask

  task automatic test_all_skip;
    int ov0, ak0;
    ov0 = ov_cnt; ak0 = ack_cnt;
    start_col(2'd0, 1'b0, 4'b1111);
    total++;
    if (col_done !== 1'b0) begin bad++; $display("[TB] FAIL allskip_early: col_done=%b want=0", col_done); end
    @(negedge clk);
    total++;
    if (col_done !== 1'b1) begin bad++; $display("[TB] FAIL allskip_done: col_done=%b want=1", col_done); end
    @(negedge clk);
    total++;
    if (ov_cnt - ov0 !== 0 || ack_cnt - ak0 !== 0 || dec_req !== 1'b0) begin
      bad++; $display("[TB] FAIL allskip_quiet: out_valid=%0d acks=%0d want 0/0", ov_cnt - ov0, ack_cnt - ak0);
    end
  endtask

  task automatic test_back_to_back;
    bit got; logic [4:0] cx; logic [1:0] idx; int ak0;
    set_nb(8'd0, 4'd0);
    ak0 = ack_cnt;
    start_col(2'd0, 1'b0, 4'b1110);
    col_start = 1'b1; rlc_ok = 1'b1; dec_ack = 1'b1; dec_d = 1'b1;
    @(negedge clk);
    col_start = 1'b0; rlc_ok = 1'b0; dec_ack = 1'b0; dec_d = 1'b0;
    wait_req(got, cx, idx);
    total++;
    if (!got || cx !== 5'd1 || ack_cnt != ak0) begin
      bad++; $display("[TB] FAIL b2b_ignore: cx=%0d acks=%0d want 1/0", cx, ack_cnt - ak0);
    end
    give_dec(1'b0);
    total++;
    if ({out_valid, out_sig} !== 2'b10) begin bad++; $display("[TB] FAIL b2b_out: got=%b want=10", {out_valid, out_sig}); end
    wait_done(got);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit got; logic [4:0] cx; logic [1:0] idx; int dn0;
    set_nb(8'd0, 4'd0);
    dn0 = done_cnt;
    start_col(2'd0, 1'b0, 4'b0000);
    wait_req(got, cx, idx);
    give_dec(1'b0);
    wait_req(got, cx, idx);
    rst_n = 1'b0;
    #1;
    total++;
    if ({dec_req, dec_cx, out_valid, out_idx, out_sig, out_sign, col_done, busy, cur_idx} !== 15'd0) begin
      bad++; $display("[TB] FAIL rstmid_outputs: got=%b want=0", {dec_req, dec_cx, out_valid, out_idx, out_sig, out_sign, col_done, busy, cur_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (done_cnt != dn0) begin bad++; $display("[TB] FAIL rstmid_nodone: col_done pulses=%0d want=0", done_cnt - dn0); end
    start_col(2'd0, 1'b0, 4'b1110);
    wait_req(got, cx, idx);
    total++;
    if (!got || cx !== 5'd1) begin bad++; $display("[TB] FAIL rstmid_zc: cx=%0d want=1", cx); end
    give_dec(1'b1);
    wait_req(got, cx, idx);
    total++;
    if (!got || cx !== 5'd13) begin bad++; $display("[TB] FAIL rstmid_sc: cx=%0d want=13", cx); end
    give_dec(1'b0);
    total++;
    if ({out_valid, out_idx, out_sig, out_sign} !== 5'b10010) begin
      bad++; $display("[TB] FAIL rstmid_out: got=%b want=10010", {out_valid, out_idx, out_sig, out_sign});
    end
    wait_done(got);
    total++;
    if (!got) begin bad++; $display("[TB] FAIL rstmid_done: col_done not seen"); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_rl_zero;
    test_rl_uniform;
    test_lh_zc_sc;
    test_zc_bands;
    test_sc_signs;
    test_skip;
    test_all_skip;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
